// File: rtl/regu_param.sv
// regu_param: index-register file with PC auto-advance and split-transaction memory loads.
// Optional macro REGU_BYPASS_EN forwards returning load data to the reads of LD_IDX.
module regu_param #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned NREG     = 8,
    parameter int unsigned PCPOS_W  = 5,
    parameter int unsigned PC_IDX   = 7,
    parameter int unsigned ACC_IDX  = 3,
    parameter int unsigned LD_IDX   = 2,
    parameter int unsigned RESET_PC = 0,
    localparam int unsigned AW      = $clog2(NREG)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_exec,
    input  logic              i_bus_we,
    input  logic [AW-1:0]     i_bus_dst,
    input  logic [DATA_W-1:0] i_bus_wdata,
    input  logic              i_bus_lo,
    input  logic              i_alu_we,
    input  logic [DATA_W-1:0] i_alu_q,
    input  logic              i_alu_lo,
    input  logic [PCPOS_W-1:0] i_pcpos,
    input  logic              i_ld_issue,
    input  logic              i_ld_valid,
    input  logic [DATA_W-1:0] i_ld_data,
    input  logic              i_ld_lo,
    input  logic [AW-1:0]     i_rd_a_idx,
    input  logic [AW-1:0]     i_rd_b_idx,
    output logic [DATA_W-1:0] o_rd_a,
    output logic [DATA_W-1:0] o_rd_b,
    output logic [DATA_W-1:0] o_pc,
    output logic [DATA_W-1:0] o_acc,
    output logic [DATA_W-1:0] o_v2,
    output logic              o_ld_busy,
    output logic              o_stall,
    output logic              o_wr_conflict
);

    typedef enum logic {StIdle, StWait} ld_state_e;

    localparam logic [AW-1:0] PcIdx  = AW'(PC_IDX);
    localparam logic [AW-1:0] AccIdx = AW'(ACC_IDX);
    localparam logic [AW-1:0] LdIdx  = AW'(LD_IDX);

    logic [DATA_W-1:0] r_regs [NREG];
    ld_state_e         r_ld_state;
    logic              r_wr_conflict;

    logic              w_busy;
    logic              w_ld_wr;
    logic              w_rd_hit;
    logic              w_rd_hazard;
    logic              w_fwd;
    logic              w_eff;
    logic              w_bus_wr;
    logic              w_alu_wr;
    logic              w_pc_adv;
    logic              w_conflict;
    logic [DATA_W-1:0] w_bus_val;
    logic [DATA_W-1:0] w_alu_val;
    logic [DATA_W-1:0] w_ld_val;
    logic [DATA_W-1:0] w_disp;
    logic [DATA_W-1:0] w_pc_next;

    assign w_busy   = (r_ld_state == StWait);
    // A returning load only counts while one is outstanding; stray ld_valid is ignored.
    assign w_ld_wr  = w_busy & i_ld_valid;
    assign w_rd_hit = (i_rd_a_idx == LdIdx) | (i_rd_b_idx == LdIdx);

`ifdef REGU_BYPASS_EN
    assign w_rd_hazard = w_rd_hit & ~i_ld_valid;
    assign w_fwd       = w_ld_wr;
`else
    assign w_rd_hazard = w_rd_hit;
    assign w_fwd       = 1'b0;
`endif

    // A pending issue is released in the completion cycle so it can start the next load.
    assign o_stall = w_busy & (w_rd_hazard
                             | (i_bus_we & (i_bus_dst == LdIdx))
                             | (i_alu_we & (AccIdx == LdIdx))
                             | (i_ld_issue & ~i_ld_valid));

    assign w_eff    = i_exec & ~o_stall;
    assign w_bus_wr = w_eff & i_bus_we;
    assign w_alu_wr = w_eff & i_alu_we;

    assign w_bus_val = i_bus_lo ? {r_regs[i_bus_dst][DATA_W-1:8], i_bus_wdata[7:0]} : i_bus_wdata;
    assign w_alu_val = i_alu_lo ? {r_regs[AccIdx][DATA_W-1:8], i_alu_q[7:0]} : i_alu_q;
    assign w_ld_val  = i_ld_lo ? {r_regs[LdIdx][DATA_W-1:8], i_ld_data[7:0]} : i_ld_data;

    assign w_disp    = {{(DATA_W - PCPOS_W){i_pcpos[PCPOS_W-1]}}, i_pcpos};
    assign w_pc_next = r_regs[PcIdx] + (w_disp << 2) + DATA_W'(4);
    assign w_pc_adv  = w_eff & ~(w_bus_wr & (i_bus_dst == PcIdx));

    assign w_conflict = (w_ld_wr & w_alu_wr & (AccIdx == LdIdx))
                      | (w_ld_wr & w_bus_wr & (i_bus_dst == LdIdx))
                      | (w_alu_wr & w_bus_wr & (i_bus_dst == AccIdx));

    // Later assignments win: priority is load > ALU > bus > PC advance.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_regs[PcIdx] <= DATA_W'(RESET_PC);
            r_wr_conflict <= 1'b0;
        end else begin
            if (w_pc_adv) r_regs[PcIdx] <= w_pc_next;
            if (w_bus_wr) r_regs[i_bus_dst] <= w_bus_val;
            if (w_alu_wr) r_regs[AccIdx] <= w_alu_val;
            if (w_ld_wr) r_regs[LdIdx] <= w_ld_val;
            r_wr_conflict <= w_conflict;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ld_state <= StIdle;
        end else begin
            case (r_ld_state)
                StIdle:  if (w_eff & i_ld_issue) r_ld_state <= StWait;
                StWait:  if (i_ld_valid & ~(w_eff & i_ld_issue)) r_ld_state <= StIdle;
                default: r_ld_state <= StIdle;
            endcase
        end
    end

    assign o_rd_a        = (w_fwd & (i_rd_a_idx == LdIdx)) ? w_ld_val : r_regs[i_rd_a_idx];
    assign o_rd_b        = (w_fwd & (i_rd_b_idx == LdIdx)) ? w_ld_val : r_regs[i_rd_b_idx];
    assign o_v2          = w_fwd ? w_ld_val : r_regs[LdIdx];
    assign o_pc          = r_regs[PcIdx];
    assign o_acc         = r_regs[AccIdx];
    assign o_ld_busy     = w_busy;
    assign o_wr_conflict = r_wr_conflict;

endmodule
